// File: rtl/dac_load_trig_sched.sv
// dac_load_trig_sched: shares one PS AXI-stream across DAC channels and schedules per-channel triggers
//   clk, rst (async, active-low)
//   load_start/load_ch/load_beats: route load_beats stream beats to channel load_ch
//   s_axis_*: PS stream in; m_axis_*: stream fanned out to channels; select_out: PS-feeds-channel
//   trig_start/trig_abort/trig_delay/trig_period/trig_repeats: trigger schedule; trigger_out: pulses
//   load_busy/trig_busy, load_done/trig_done: status; err: sticky rejected-command flag
module dac_load_trig_sched #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [15:0]             load_beats,
    input  logic [255:0]            s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [255:0]            m_axis_tdata,
    output logic [NUM_CH-1:0]       m_axis_tvalid,
    input  logic [NUM_CH-1:0]       m_axis_tready,
    output logic [NUM_CH-1:0]       select_out,
    input  logic                    trig_start,
    input  logic                    trig_abort,
    input  logic [NUM_CH*CNT_W-1:0] trig_delay,
    input  logic [CNT_W-1:0]        trig_period,
    input  logic [15:0]             trig_repeats,
    output logic [NUM_CH-1:0]       trigger_out,
    output logic                    load_busy,
    output logic                    trig_busy,
    output logic                    load_done,
    output logic                    trig_done,
    output logic                    err
);
    typedef enum logic {L_IDLE, L_RUN} l_state_t;
    typedef enum logic {T_IDLE, T_RUN} t_state_t;
    l_state_t l_state, l_next;
    t_state_t t_state, t_next;
    logic [CH_W-1:0] ch_q;
    logic [15:0] beats_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [15:0] rem [NUM_CH];
    logic ch_bad, load_ok, trig_ok, hs, last_beat, all_done, load_done_d, err_d;

    assign ch_bad = {1'b0, load_ch} >= NUM_CH[CH_W:0];
    assign load_busy = l_state == L_RUN;
    assign trig_busy = t_state == T_RUN;
    assign load_ok = load_start && !load_busy && !trig_busy && !ch_bad;
    // a simultaneous load_start takes precedence over trig_start
    assign trig_ok = trig_start && !trig_busy && !load_busy && !load_start;
    assign hs = load_busy && s_axis_tvalid && s_axis_tready;
    assign last_beat = hs && beats_q == 16'd1;
    assign m_axis_tdata = s_axis_tdata;
    assign s_axis_tready = load_busy && m_axis_tready[ch_q];
    // start during an abort cycle is silently dropped rather than flagged
    assign err_d = (load_start && !load_ok) || (trig_start && !trig_ok && !(trig_busy && trig_abort));

    always_comb begin
        m_axis_tvalid = '0;
        for (int c = 0; c < NUM_CH; c++)
            m_axis_tvalid[c] = load_busy && s_axis_tvalid && ch_q == CH_W'(c);
    end

    always_comb begin
        all_done = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            all_done = all_done && rem[c] == '0;
    end

    always_comb begin
        l_next = l_state;
        t_next = t_state;
        load_done_d = (load_ok && load_beats == '0) || last_beat;
        if (load_ok && load_beats != '0) l_next = L_RUN;
        if (last_beat) l_next = L_IDLE;
        // zero repeats still enter T_RUN so trig_done lands one cycle later
        if (trig_ok) t_next = T_RUN;
        if (trig_busy && (trig_abort || all_done)) t_next = T_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_state <= L_IDLE;
            t_state <= T_IDLE;
        end else begin
            l_state <= l_next;
            t_state <= t_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q <= '0;
            beats_q <= '0;
            period_q <= '0;
            select_out <= '0;
            trigger_out <= '0;
            load_done <= 1'b0;
            trig_done <= 1'b0;
            err <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= '0;
                rem[c] <= '0;
            end
        end else begin
            load_done <= load_done_d;
            trig_done <= trig_busy && !trig_abort && all_done;
            err <= err || err_d;
            trigger_out <= '0;
            if (load_ok) begin
                ch_q <= load_ch;
                beats_q <= load_beats;
                select_out <= load_beats != '0 ? NUM_CH'(1) << load_ch : '0;
            end else if (hs) begin
                beats_q <= beats_q - 16'd1;
            end
            if (last_beat) select_out <= '0;
            if (trig_ok) begin
                period_q <= trig_period == '0 ? CNT_W'(1) : trig_period;
                for (int c = 0; c < NUM_CH; c++) begin
                    cnt[c] <= trig_delay[c*CNT_W +: CNT_W];
                    rem[c] <= trig_repeats;
                end
            end else if (trig_busy && !trig_abort) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (rem[c] != '0) begin
                        if (cnt[c] == '0) begin
                            trigger_out[c] <= 1'b1;
                            rem[c] <= rem[c] - 16'd1;
                            cnt[c] <= period_q - CNT_W'(1);
                        end else begin
                            cnt[c] <= cnt[c] - CNT_W'(1);
                        end
                    end
                end
            end
        end
    end
endmodule

// File: doc/dac_load_trig_sched.md
# dac_load_trig_sched

Controller that sequences a bank of `NUM_CH` DAC driver channels from one PS-side source. It shares a single 256-bit PS AXI-stream between channels for waveform loading, steering one channel at a time and driving that channel's `select_in`. It also generates time-aligned per-channel `trigger_in` pulses with programmable start delay, repeat period and repeat count. It sits between the PS DMA/GPIO registers and the per-channel `dac_driver` instances.

## Interface
- `NUM_CH`, 4, number of DAC channels served (2..16).
- `CNT_W`, 32, width of delay/period counters.
- `clk  in  1  single clock for all logic`
- `rst  in  1  asynchronous, active-low reset`
- `load_start  in  1  one-cycle pulse: begin load`
- `load_ch  in  $clog2(NUM_CH)  target channel, sampled with load_start`
- `load_beats  in  16  beats to route, sampled with load_start`
- `s_axis_tdata/tvalid/tready  in/in/out  256/1/1  PS stream`
- `m_axis_tdata  out  256  shared data to all channels (= s_axis_tdata)`
- `m_axis_tvalid  out  NUM_CH  per-channel valid`
- `m_axis_tready  in  NUM_CH  per-channel ready`
- `select_out  out  NUM_CH  to each channel's select_in; 1 = PS feeds channel`
- `trig_start  in  1  one-cycle pulse: start trigger schedule`
- `trig_abort  in  1  one-cycle pulse: stop schedule`
- `trig_delay  in  NUM_CH*CNT_W  per-channel start delay, channel c in bits [c*CNT_W +: CNT_W]`
- `trig_period  in  CNT_W  cycles between repeats`
- `trig_repeats  in  16  pulses per channel`
- `trigger_out  out  NUM_CH  to each channel's trigger_in`
- `load_busy, trig_busy  out  1  FSM not idle`
- `load_done, trig_done  out  1  one-cycle completion pulses`
- `err  out  1  sticky: rejected command; cleared only by reset`

## Operation
- Reset: all outputs 0, both FSMs IDLE, counters 0.
- Load FSM states: L_IDLE, L_RUN.
  - L_IDLE + load_start: if trig_busy, or load_ch >= NUM_CH, set err and stay idle. If load_beats == 0, pulse load_done next cycle and do not assert select. Otherwise latch ch and beats, go to L_RUN, and set select_out[ch] = 1.
  - L_RUN: combinational pass-through: m_axis_tvalid[ch] = s_axis_tvalid and s_axis_tready = m_axis_tready[ch]; other valids 0. Count handshakes (s_axis_tvalid & s_axis_tready). On the handshake of the final beat, go to L_IDLE; select_out clears and load_done pulses on the next cycle.
  - L_IDLE: s_axis_tready = 0 and all m_axis_tvalid = 0.
  - load_start during L_RUN: ignored, err set.
- Trigger FSM states: T_IDLE, T_RUN.
  - T_IDLE + trig_start: if load_busy, set err and stay idle. Otherwise latch delays, period and repeats. trig_period == 0 is treated as 1. If trig_repeats == 0, pulse trig_done next cycle with no triggers. Otherwise go to T_RUN.
  - T_RUN: each channel has its own down-counter (loaded with its delay) and remaining count (loaded with repeats). When a channel's counter reaches 0 with remaining > 0, it emits a one-cycle trigger_out[c] pulse, decrements remaining, and reloads the counter with period-1.
  - When all remaining counts reach 0, go to T_IDLE and pulse trig_done once.
  - trig_abort in T_RUN: go to T_IDLE next cycle, no further pulses, no trig_done. If abort and start arrive in the same cycle, abort wins and start is ignored.
  - trig_start during T_RUN: ignored, err set.
- If load_start and trig_start arrive in the same cycle with both FSMs idle, load wins; trig_start is rejected and err is set.
- Reset mid-operation: immediate return to reset state. Any partial load is abandoned; the channel FIFO contents are the software's concern.

## Timing
- trigger_out, select_out, load_done, trig_done, busy and err are registered.
- trig_start sampled at edge T: trigger_out[c] first high in cycle T+1+delay[c], then every period cycles, repeats times total.
- trig_done is high in the cycle after the last trigger pulse of the slowest channel.
- Load: select_out[ch] rises the cycle after load_start. Data path has zero latency (combinational). load_done is high one cycle after the final handshake.
- Channels with equal delay pulse in the same cycle (skew 0).
- Counter arithmetic is CNT_W-bit unsigned with no overflow. Maximum delay is 2^CNT_W-1.

## Test plan
- Load ch2, 8 beats, with m_axis_tready[2] toggling 1/0 → exactly 8 beats reach ch2. No other tvalid is asserted. select_out = 4'b0100 during the load. load_done occurs once, 1 cycle after the 8th handshake.
- Trigger with delays {0,3,3,10}, period 5, repeats 3 → ch0 pulses at T+1, 6, 11; ch1/ch2 at T+4, 9, 14; ch3 at T+11, 16, 21. trig_done at T+22.
- trig_repeats 0 → no trigger_out, trig_done at T+1. Period 0 with repeats 3 → pulses on 3 consecutive cycles.
- trig_abort 2 cycles after the first ch0 pulse → no further pulses, no trig_done, trig_busy low next cycle.
- trig_start during an active load, and load_ch = NUM_CH → both rejected, err = 1, FSM states unchanged.
- Assert rst mid-load and mid-trigger → all outputs 0 immediately. A fresh 4-beat load then completes normally.
